// File: rtl/uc_control.sv
// rtl/uc_control.sv - accumulator CPU control unit: fetch, decode and processing-unit strobes
`timescale 1ns/1ps
module uc_control #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [15:0]       data_in,
    input  logic              carry,
    output logic [ADDR_W-1:0] adr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        sel_UAL,
    output logic              load_R1,
    output logic              load_accu,
    output logic              load_carry,
    output logic              init_carry
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_OPLOAD = 3'd2;
    localparam logic [2:0] S_R1LOAD = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;

    localparam logic [1:0] C_ALU = 2'b00;
    localparam logic [1:0] C_STA = 2'b01;
    localparam logic [1:0] C_JMP = 2'b10;
    localparam logic [1:0] C_JCC = 2'b11;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] din_addr;
    logic              active;

    logic [ADDR_W-1:0] adr_raw;
    logic              en_raw;
    logic              we_raw;
    logic [2:0]        sel_raw;
    logic              r1_raw;
    logic              accu_raw;
    logic              cy_raw;
    logic              ic_raw;

    assign pc_inc   = pc + ADDR_W'(1);
    assign ir_addr  = ir[ADDR_W-1:0];
    assign din_addr = data_in[ADDR_W-1:0];
    assign active   = ce & ~rst;

    // Sequencing and PC update; DECODE works on the word arriving on data_in,
    // so the branch decision sees the carry before init_carry clears it
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                pc_nxt = pc_inc;
                case (data_in[15:14])
                    C_ALU: state_nxt = S_OPLOAD;
                    C_STA: state_nxt = S_STORE;
                    C_JMP: begin
                        pc_nxt    = din_addr;
                        state_nxt = S_FETCH;
                    end
                    default: begin
                        if (!carry) begin
                            pc_nxt = din_addr;
                        end
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_OPLOAD: state_nxt = S_R1LOAD;
            S_R1LOAD: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_FETCH;
            S_STORE:  state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // State, PC and IR registers; ce=0 freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else if (ce) begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_DECODE) begin
                ir <= data_in;
            end
        end
    end

    // Ungated output decode from the registered state and IR
    always_comb begin
        adr_raw  = pc;
        en_raw   = 1'b0;
        we_raw   = 1'b0;
        sel_raw  = 3'b000;
        r1_raw   = 1'b0;
        accu_raw = 1'b0;
        cy_raw   = 1'b0;
        ic_raw   = 1'b0;
        case (state)
            S_FETCH:  en_raw = 1'b1;
            S_DECODE: ic_raw = (data_in[15:14] == C_JCC);
            S_OPLOAD: begin
                adr_raw = ir_addr;
                en_raw  = 1'b1;
            end
            S_R1LOAD: r1_raw = 1'b1;
            S_EXEC: begin
                if (ir[15:14] == C_ALU) begin
                    sel_raw  = ir[13:11];
                    accu_raw = 1'b1;
                    cy_raw   = 1'b1;
                end
            end
            S_STORE: begin
                if (ir[15:14] == C_STA) begin
                    adr_raw = ir_addr;
                    en_raw  = 1'b1;
                    we_raw  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Every strobe is suppressed while frozen or in reset; the address reads 0 in reset
    always_comb begin
        adr        = rst ? '0 : adr_raw;
        mem_en     = en_raw & active;
        mem_we     = we_raw & active;
        sel_UAL    = active ? sel_raw : 3'b000;
        load_R1    = r1_raw & active;
        load_accu  = accu_raw & active;
        load_carry = cy_raw & active;
        init_carry = ic_raw & active;
    end

endmodule
